// File: rtl/xpb_pkg.sv
// rtl/xpb_pkg.sv - constants, state encoding and limb slicing shared by the xpb accumulator
package xpb_pkg;
   localparam int DATA_W    = 1024;
   localparam int LIMB_W    = 64;
   localparam int NUM_LIMBS = DATA_W / LIMB_W + 1;
   localparam int ACC_W     = NUM_LIMBS * LIMB_W;
   localparam int CNT_W     = 8;

   typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

   function automatic logic [LIMB_W-1:0] limb_slice(input logic [DATA_W-1:0] d, input int idx);
      return d[idx*LIMB_W +: LIMB_W];
   endfunction
endpackage

// File: rtl/xpb_acc_limb.sv
// rtl/xpb_acc_limb.sv - one accumulator limb; its carry is registered and consumed by the next limb a cycle later
module xpb_acc_limb
   import xpb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              add_en_i,
   input  logic [LIMB_W-1:0] term_i,
   input  logic              carry_i,
   output logic [LIMB_W-1:0] acc_o,
   output logic              carry_o,
   output logic              nc_o
);
   logic [LIMB_W-1:0] acc_q;
   logic              carry_q;
   logic [LIMB_W:0]   sum_d;

   assign sum_d = {1'b0, acc_q} + {1'b0, term_i} + {{LIMB_W{1'b0}}, carry_i};
   assign nc_o  = sum_d[LIMB_W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
      end else if (clear_i) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
      end else if (add_en_i) begin
         acc_q   <= sum_d[LIMB_W-1:0];
         carry_q <= sum_d[LIMB_W];
      end
   end

   assign acc_o   = acc_q;
   assign carry_o = carry_q;
endmodule

// File: rtl/xpb_accumulator.sv
// rtl/xpb_accumulator.sv - sums a stream of xpb terms with a limb-split adder, flushes carries, then offers the result
module xpb_accumulator
   import xpb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              out_valid,
   output logic [ACC_W-1:0]  out_data,
   output logic [CNT_W-1:0]  out_count,
   input  logic              out_ready
);
   state_t               state_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic [CNT_W-1:0]     count_q;
   logic [CNT_W-1:0]     count_d;
   logic                 accept;
   logic                 add_en;
   logic                 limb_clear;
   logic                 nc_any;
   logic [NUM_LIMBS-1:0] carry_q;
   logic [NUM_LIMBS-1:0] nc;
   logic [ACC_W-1:0]     acc_flat;
   logic                 unused_top_carry;

   assign accept     = in_valid & in_ready_q;
   assign add_en     = accept | (state_q == FLUSH);
   assign limb_clear = clr | (out_valid_q & out_ready);
   assign count_d    = (count_q == '1) ? count_q : count_q + CNT_W'(1);

   // The headroom limb's carry can never be set, so it takes no part in the flush decision.
   assign nc_any           = |nc[NUM_LIMBS-2:0];
   assign unused_top_carry = carry_q[NUM_LIMBS-1] ^ nc[NUM_LIMBS-1];

   for (genvar i = 0; i < NUM_LIMBS; i++) begin : g_limb
      logic [LIMB_W-1:0] term;
      logic              cin;
      if (i < NUM_LIMBS - 1) begin : g_data
         assign term = accept ? limb_slice(in_data, i) : '0;
      end else begin : g_head
         assign term = '0;
      end
      if (i == 0) begin : g_c0
         assign cin = 1'b0;
      end else begin : g_cn
         assign cin = carry_q[i-1];
      end
      xpb_acc_limb u_limb (
         .clk      (clk),
         .reset    (reset),
         .clear_i  (limb_clear),
         .add_en_i (add_en),
         .term_i   (term),
         .carry_i  (cin),
         .acc_o    (acc_flat[i*LIMB_W +: LIMB_W]),
         .carry_o  (carry_q[i]),
         .nc_o     (nc[i])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else if (clr) begin
         state_q     <= IDLE;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  count_q <= count_d;
                  if (in_last) begin
                     in_ready_q <= 1'b0;
                     if (nc_any) begin
                        state_q <= FLUSH;
                     end else begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                     end
                  end else begin
                     state_q <= ACCUM;
                  end
               end
            end
            FLUSH: begin
               if (!nc_any) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  count_q     <= '0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = acc_flat;
   assign out_count = count_q;
endmodule

// File: tb/tb_xpb_accumulator.sv
// tb/tb_xpb_accumulator.sv - randomized scoreboard bench for xpb_accumulator against a big-integer sum model
module tb_xpb_accumulator;
   import xpb_pkg::*;

   typedef struct {
      logic [ACC_W-1:0] data;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              clr;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_ready;
   logic              out_valid;
   logic [ACC_W-1:0]  out_data;
   logic [CNT_W-1:0]  out_count;
   logic              out_ready;

   int               vectors = 0;
   int               miscompares = 0;
   exp_t             exp_q[$];
   logic [ACC_W-1:0] ref_sum;
   int               ref_cnt;
   bit               seen;

   always #5 clk = ~clk;

   xpb_accumulator dut (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_count (out_count),
      .out_ready (out_ready)
   );

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got %0d exp %0d", name, got, exp);
      end
   endtask

   task automatic check_wide(input string name, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
      vectors++;
      if (got !== exp) begin
         int k = 0;
         miscompares++;
         for (int i = 0; i < NUM_LIMBS; i++) begin
            if (got[i*LIMB_W +: LIMB_W] !== exp[i*LIMB_W +: LIMB_W]) begin
               k = i;
               break;
            end
         end
         $display("FAIL %s limb %0d got %h exp %h", name, k,
                  got[k*LIMB_W +: LIMB_W], exp[k*LIMB_W +: LIMB_W]);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_term();
      logic [DATA_W-1:0] t;
      for (int i = 0; i < DATA_W / 32; i++) t[i*32 +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0) t = '1;
      return t;
   endfunction

   task automatic ref_clear();
      ref_sum = '0;
      ref_cnt = 0;
   endtask

   // Presents one beat and holds it until the DUT takes it; the model is updated on acceptance.
   task automatic send(input logic [DATA_W-1:0] d, input bit last, input int gap);
      int  n;
      bit  taken;
      exp_t e;
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      n = 0;
      forever begin
         @(negedge clk);
         taken = in_ready;
         @(posedge clk);
         #1;
         if (taken) break;
         n++;
         if (n > 200) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout got in_ready 0 exp 1 within 200 cycles");
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (taken) begin
         ref_sum = ref_sum + {{(ACC_W-DATA_W){1'b0}}, d};
         if (ref_cnt < (1 << CNT_W) - 1) ref_cnt++;
         if (last) begin
            e.data = ref_sum;
            e.cnt  = CNT_W'(ref_cnt);
            exp_q.push_back(e);
            ref_clear();
         end
      end
   endtask

   // lat = 1 means out_valid is seen in the cycle right after the accepting edge.
   task automatic wait_result(output int lat);
      lat = 1;
      forever begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         #1;
         lat++;
         if (lat > 100) begin
            vectors++;
            miscompares++;
            $display("FAIL result_timeout got out_valid 0 exp 1 within 100 cycles");
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (reset || !out_valid) begin
            seen = 1'b0;
         end else if (!seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_result got out_valid 1 count %0d exp no result", out_count);
            end else begin
               e = exp_q.pop_front();
               check_wide("result_data", out_data, e.data);
               check("result_count", int'(out_count), int'(e.cnt));
            end
         end
      end
   end

   initial begin
      int                lat;
      int                n;
      int                hits;
      logic [DATA_W-1:0] ones;
      logic [DATA_W-1:0] tv;
      logic [ACC_W-1:0]  tv_wide;

      ones = '1;
      reset = 1'b1;
      clr = 1'b0;
      in_valid = 1'b0;
      in_last = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      ref_clear();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_count", int'(out_count), 0);
      check_wide("reset_out_data", out_data, '0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      send(DATA_W'(1), 1'b1, 0);
      wait_result(lat);
      check("single_latency", lat, 1);

      send(ones, 1'b0, 1);
      send(ones, 1'b1, 0);
      wait_result(lat);
      check("one_flush_latency", lat, 2);

      send(ones, 1'b0, 1);
      send(DATA_W'(1), 1'b1, 0);
      wait_result(lat);
      check("ripple_latency", lat, 17);

      out_ready = 1'b0;
      tv = rand_term();
      tv_wide = {{(ACC_W-DATA_W){1'b0}}, tv};
      send(tv, 1'b1, 1);
      wait_result(lat);
      in_valid = 1'b1;
      in_last = 1'b1;
      in_data = rand_term();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_out_valid", int'(out_valid), 1);
         check_wide("bp_out_data", out_data, tv_wide);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_release_out_valid", int'(out_valid), 0);
      check("bp_release_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      send(rand_term(), 1'b1, 0);
      wait_result(lat);

      for (int k = 0; k < 3; k++) send(rand_term(), 1'b0, 0);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      ref_clear();
      send(DATA_W'(5), 1'b1, 0);
      wait_result(lat);

      send(rand_term(), 1'b0, 0);
      in_valid = 1'b1;
      in_last = 1'b1;
      in_data = rand_term();
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      in_valid = 1'b0;
      in_last = 1'b0;
      ref_clear();
      hits = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) hits++;
      end
      check("clr_last_no_valid", hits, 0);
      check("clr_last_count", int'(out_count), 0);
      @(posedge clk);
      #1;

      for (int k = 0; k < 260; k++) send(rand_term(), k == 259, 0);
      wait_result(lat);

      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(1, 32);
         for (int k = 0; k < n; k++) send(rand_term(), k == n - 1, $urandom_range(0, 3));
         wait_result(lat);
         check("rand_latency_bound", int'(lat <= 17), 1);
      end

      send(ones, 1'b0, 0);
      send(DATA_W'(1), 1'b1, 0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("flush_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_out_valid", int'(out_valid), 0);
      check("async_rst_in_ready", int'(in_ready), 1);
      check("async_rst_out_count", int'(out_count), 0);
      check_wide("async_rst_out_data", out_data, '0);
      exp_q.delete();
      ref_clear();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      send(DATA_W'(7), 1'b1, 0);
      wait_result(lat);
      check("post_rst_latency", lat, 1);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
